// File: rtl/oki_bank_arbiter_if.sv
// Bus bundle between the OKI-side clients, the bank-register writer and the
// shared SDRAM slot. "slave" is the arbiter's view; "master" is everything
// around it (OKI address sources, CPU bank writes, SDRAM responder).
interface oki_bank_arbiter_if #(
    parameter int CHIPS  = 2,
    parameter int ROM_AW = 21
);
    localparam int SEL_W = $clog2(CHIPS) + 2;

    logic                  WR;
    logic [SEL_W-1:0]      WSEL;
    logic [7:0]            WDATA;
    logic [CHIPS*18-1:0]   REQ_ADDR;
    logic [CHIPS*8-1:0]    REQ_DATA;
    logic [CHIPS-1:0]      REQ_OK;
    logic                  ROM_CS;
    logic [ROM_AW-1:0]     ROM_ADDR;
    logic [7:0]            ROM_DOUT;
    logic                  ROM_OK;

    modport master (
        output WR, WSEL, WDATA, REQ_ADDR, ROM_DOUT, ROM_OK,
        input  REQ_DATA, REQ_OK, ROM_CS, ROM_ADDR
    );

    modport slave (
        input  WR, WSEL, WDATA, REQ_ADDR, ROM_DOUT, ROM_OK,
        output REQ_DATA, REQ_OK, ROM_CS, ROM_ADDR
    );
endinterface

// File: rtl/oki_bank_arbiter.sv
// NMK112-style bank translation (with optional table paging) for CHIPS OKI
// chips, plus a one-entry cache per chip and a round-robin arbiter that
// funnels every chip's ROM fetch onto a single shared SDRAM slot.
module oki_bank_arbiter #(
    parameter int               CHIPS     = 2,
    parameter int               ROM_AW    = 21,
    parameter int unsigned      CHIP_OFFS = 'h100000,
    parameter logic [CHIPS-1:0] PAGE_MASK = {CHIPS{1'b1}}
) (
    input logic               CLK,
    input logic               RESET,
    oki_bank_arbiter_if.slave bus
);
    localparam int SEL_W = $clog2(CHIPS) + 2;
    localparam int CW    = (CHIPS > 1) ? $clog2(CHIPS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT1 = 2'd1;   // first wait cycle: ROM_OK is stale
    localparam logic [1:0] ST_WAIT2 = 2'd2;   // ROM_OK now completes the fetch

    logic [7:0]        bank_reg [CHIPS][4];
    logic [1:0]        state_reg;
    logic              rom_cs_reg;
    logic [ROM_AW-1:0] rom_addr_reg;
    logic [CW-1:0]     grant_reg;
    logic [CW-1:0]     last_reg;
    logic [17:0]       gtag_reg;
    logic              discard_reg;

    logic              wr_hit;
    logic [CW-1:0]     wr_chip;
    logic [1:0]        wr_slot;
    logic [17:0]       req_addr [CHIPS];
    logic [CHIPS-1:0]  ok_vec;
    logic [CHIPS*8-1:0] data_vec;
    logic              fill;
    logic              wr_on_grant;

    logic [CW-1:0]     pick;
    logic              pick_vld;
    logic [17:0]       pick_addr;
    logic [1:0]        pick_slot;
    logic [23:0]       pick_t;
    logic [ROM_AW-1:0] pick_rom;

    // Write-select decode; a chip field beyond the last chip is dropped.
    generate
        if (CHIPS > 1) begin : g_multi
            assign wr_chip = bus.WSEL[SEL_W-1:2];
            assign wr_hit  = bus.WR && (int'(bus.WSEL[SEL_W-1:2]) < CHIPS);
        end else begin : g_single
            assign wr_chip = 1'b0;
            assign wr_hit  = bus.WR;
        end
    endgenerate

    assign wr_slot     = bus.WSEL[1:0];
    assign wr_on_grant = wr_hit && (wr_chip == grant_reg);
    // A fetch overlapped by a bank write to its chip used stale banks.
    assign fill        = (state_reg == ST_WAIT2) && bus.ROM_OK && !discard_reg && !wr_on_grant;

    // Per-chip one-entry cache: hit compare is combinational against the live address.
    genvar gi;
    generate
        for (gi = 0; gi < CHIPS; gi++) begin : g_chip
            logic [17:0] tag_reg;
            logic [7:0]  data_reg;
            logic        valid_reg;

            assign req_addr[gi]         = bus.REQ_ADDR[18*gi +: 18];
            assign ok_vec[gi]           = valid_reg && (tag_reg == req_addr[gi]);
            assign data_vec[8*gi +: 8]  = data_reg;

            // Fill on completion; any bank write to this chip invalidates it.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    tag_reg   <= '0;
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    if (fill && grant_reg == CW'(gi)) begin
                        tag_reg   <= gtag_reg;
                        data_reg  <= bus.ROM_DOUT;
                        valid_reg <= 1'b1;
                    end
                    if (wr_hit && wr_chip == CW'(gi)) begin
                        valid_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign bus.REQ_OK   = ok_vec;
    assign bus.REQ_DATA = data_vec;
    assign bus.ROM_CS   = rom_cs_reg;
    assign bus.ROM_ADDR = rom_addr_reg;

    // Round-robin pick: first pending chip after the last one served.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= CHIPS; k++) begin
            if (!pick_vld && !ok_vec[CW'((int'(last_reg) + k) % CHIPS)]) begin
                pick_vld = 1'b1;
                pick     = CW'((int'(last_reg) + k) % CHIPS);
            end
        end
    end

    // Bank translation of the picked chip's address; paging uses A[9:8] below 0x400.
    always_comb begin
        pick_addr = req_addr[pick];
        if (PAGE_MASK[pick] && pick_addr < 18'h400) begin
            pick_slot = pick_addr[9:8];
        end else begin
            pick_slot = pick_addr[17:16];
        end
        pick_t   = {bank_reg[pick][pick_slot], pick_addr[15:0]};
        pick_rom = ROM_AW'(64'(pick) * 64'(CHIP_OFFS)) + ROM_AW'(pick_t);
    end

    // Bank register file.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int c = 0; c < CHIPS; c++) begin
                for (int s = 0; s < 4; s++) begin
                    bank_reg[c][s] <= '0;
                end
            end
        end else if (wr_hit) begin
            bank_reg[wr_chip][wr_slot] <= bus.WDATA;
        end
    end

    // Arbiter FSM: grant in IDLE, hold the request through WAIT, one IDLE cycle between fetches.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg    <= ST_IDLE;
            rom_cs_reg   <= 1'b0;
            rom_addr_reg <= '0;
            grant_reg    <= '0;
            last_reg     <= CW'(CHIPS - 1);
            gtag_reg     <= '0;
            discard_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_reg    <= pick;
                        gtag_reg     <= pick_addr;
                        rom_addr_reg <= pick_rom;
                        rom_cs_reg   <= 1'b1;
                        discard_reg  <= wr_hit && (wr_chip == pick);
                        state_reg    <= ST_WAIT1;
                    end
                end
                ST_WAIT1: begin
                    if (wr_on_grant) begin
                        discard_reg <= 1'b1;
                    end
                    state_reg <= ST_WAIT2;
                end
                ST_WAIT2: begin
                    if (wr_on_grant) begin
                        discard_reg <= 1'b1;
                    end
                    if (bus.ROM_OK) begin
                        rom_cs_reg <= 1'b0;
                        last_reg   <= grant_reg;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    rom_cs_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_oki_bank_arbiter.sv
// Bench for oki_bank_arbiter: directed steps from the test plan followed by
// a randomized phase, all compared against a fetch-level reference model.
module tb_oki_bank_arbiter;
    localparam int          CHIPS  = 2;
    localparam int          ROM_AW = 21;
    localparam logic [1:0]  PMASK  = 2'b10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oki_bank_arbiter_if #(.CHIPS(CHIPS), .ROM_AW(ROM_AW)) bus ();

    oki_bank_arbiter #(
        .CHIPS(CHIPS), .ROM_AW(ROM_AW), .CHIP_OFFS('h100000), .PAGE_MASK(PMASK)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .bus(bus.slave)
    );

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    // ROM contents: a fixed hash of the address.
    function automatic logic [7:0] rom_byte(input logic [20:0] a);
        logic [31:0] x;
        x = {11'd0, a} * 32'h9E37_79B1;
        return x[23:16] ^ a[7:0];
    endfunction

    assign bus.ROM_DOUT = rom_byte(bus.ROM_ADDR);

    // Reference model state
    int unsigned m_bank [CHIPS][4];
    bit          m_valid [CHIPS];
    int unsigned m_tag [CHIPS];
    int unsigned m_data [CHIPS];
    int          m_last;
    bit          m_busy;
    int          m_since;
    bit          m_taint;
    int          m_gchip;
    int unsigned m_gaddr;
    int unsigned m_gexp;
    int unsigned pmask = PMASK;
    int unsigned pool [8] = '{'h00000, 'h00123, 'h003FF, 'h00400,
                              'h10000, 'h1FFFF, 'h2ABCD, 'h3FFFF};

    function automatic int unsigned xlate(input int c, input int unsigned a);
        int unsigned slot, t;
        if (((pmask >> c) & 1) == 1 && a < 'h400) slot = (a / 256) % 4;
        else slot = a / 65536;
        t = m_bank[c][slot] * 65536 + (a % 65536);
        return (c * 'h100000 + t) % (1 << ROM_AW);
    endfunction

    function automatic int unsigned cur_addr(input int c);
        return int'(bus.REQ_ADDR[18*c +: 18]);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHIPS; c++) begin
            for (int s = 0; s < 4; s++) m_bank[c][s] = 0;
            m_valid[c] = 0;
            m_tag[c]   = 0;
            m_data[c]  = 0;
        end
        m_last = CHIPS - 1;
        m_busy = 0;
        m_since = 0;
        m_taint = 0;
        m_gchip = 0;
        m_gaddr = 0;
        m_gexp = 0;
    endtask

    // One clock edge of the fetch lifecycle, from the inputs presented before it.
    task automatic model_step();
        int wc, c;
        bit wv;
        int unsigned a;
        wc = int'(bus.WSEL) >> 2;
        wv = bus.WR && (wc < CHIPS);
        if (m_busy) begin
            m_since++;
            if (wv && wc == m_gchip) m_taint = 1;
            if (m_since >= 2 && bus.ROM_OK) begin
                if (!m_taint) begin
                    m_valid[m_gchip] = 1;
                    m_tag[m_gchip]   = m_gaddr;
                    m_data[m_gchip]  = rom_byte(21'(m_gexp));
                end
                m_last = m_gchip;
                m_busy = 0;
            end
        end else begin
            for (int k = 1; k <= CHIPS; k++) begin
                c = (m_last + k) % CHIPS;
                a = cur_addr(c);
                if (!m_busy && !(m_valid[c] && m_tag[c] == a)) begin
                    m_busy  = 1;
                    m_since = 0;
                    m_gchip = c;
                    m_gaddr = a;
                    m_gexp  = xlate(c, a);
                    m_taint = wv && (wc == c);
                end
            end
        end
        if (wv) begin
            m_bank[wc][bus.WSEL[1:0]] = bus.WDATA;
            m_valid[wc] = 0;
        end
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < CHIPS; c++) begin
            chk($sformatf("req_ok[%0d]", c), 32'(bus.REQ_OK[c]),
                32'(m_valid[c] && m_tag[c] == cur_addr(c)));
            chk($sformatf("req_data[%0d]", c), 32'(bus.REQ_DATA[8*c +: 8]), m_data[c]);
        end
        chk("rom_cs", 32'(bus.ROM_CS), 32'(m_busy));
        if (m_busy) chk("rom_addr", 32'(bus.ROM_ADDR), m_gexp);
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic set_addr(input int c, input int unsigned a);
        bus.REQ_ADDR[18*c +: 18] = 18'(a);
    endtask

    task automatic bank_write(input int c, input int s, input int unsigned d);
        bus.WR    = 1'b1;
        bus.WSEL  = 3'(c * 4 + s);
        bus.WDATA = 8'(d);
        tick();
        bus.WR    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.WR = 1'b0;
        bus.WSEL = '0;
        bus.WDATA = '0;
        bus.REQ_ADDR = '0;
        bus.ROM_OK = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("reset_rom_cs", 32'(bus.ROM_CS), 32'h0);
        chk("reset_rom_addr", 32'(bus.ROM_ADDR), 32'h0);
        chk("reset_req_ok", 32'(bus.REQ_OK), 32'h0);
        chk("reset_req_data", 32'(bus.REQ_DATA), 32'h0);
        rst = 1'b0;
        bus.ROM_OK = 1'b1;          // held high: also exercises the stale-ack rule
        tick_n(8);

        // Plain translation, minimum latency
        bank_write(0, 1, 'h05);
        tick_n(6);
        set_addr(0, 'h12345);
        tick();
        chk("plain_cs_rise", 32'(bus.ROM_CS), 32'h1);
        chk("plain_rom_addr", 32'(bus.ROM_ADDR), 32'h052345);
        tick();
        chk("stale_ack_cs", 32'(bus.ROM_CS), 32'h1);
        chk("stale_ack_ok", 32'(bus.REQ_OK[0]), 32'h0);
        tick();
        chk("plain_cs_fall", 32'(bus.ROM_CS), 32'h0);
        chk("plain_req_ok", 32'(bus.REQ_OK[0]), 32'h1);
        chk("plain_req_data", 32'(bus.REQ_DATA[7:0]), 32'(rom_byte(21'h052345)));

        // Unpaged chip (chip0): low address still uses A[17:16]
        bank_write(0, 0, 'h03);
        tick_n(6);
        set_addr(0, 'h00234);
        tick();
        chk("nopage_rom_addr", 32'(bus.ROM_ADDR), 32'h030234);
        tick_n(4);

        // Paged chip (chip1): low address uses A[9:8]
        bank_write(1, 2, 'h07);
        tick_n(6);
        set_addr(1, 'h00234);
        tick();
        chk("page_rom_addr", 32'(bus.ROM_ADDR), 32'h170234);
        tick_n(2);
        chk("page_req_ok", 32'(bus.REQ_OK[1]), 32'h1);
        tick_n(2);

        // Round robin, last served = chip1 -> chip0 first
        set_addr(0, 'h10000);
        set_addr(1, 'h20001);
        tick();
        chk("rr_first_addr", 32'(bus.ROM_ADDR), 32'h050000);
        tick_n(2);
        chk("rr_gap_cs", 32'(bus.ROM_CS), 32'h0);
        tick();
        chk("rr_second_cs", 32'(bus.ROM_CS), 32'h1);
        chk("rr_second_addr", 32'(bus.ROM_ADDR), 32'h170001);
        tick_n(2);
        chk("rr_second_ok", 32'(bus.REQ_OK[1]), 32'h1);
        set_addr(0, 'h10001);       // serve chip0 alone: last = chip0
        tick_n(3);
        set_addr(0, 'h10002);
        set_addr(1, 'h20002);
        tick();
        chk("rr_chip1_first", 32'(bus.ROM_ADDR), 32'h170002);
        tick_n(5);

        // Bank write while chip0 is in WAIT: discard then refetch
        set_addr(0, 'h00777);
        tick();
        chk("midwr_first_addr", 32'(bus.ROM_ADDR), 32'h030777);
        bank_write(0, 0, 'h09);
        tick();
        chk("midwr_cs_fall", 32'(bus.ROM_CS), 32'h0);
        chk("midwr_discard", 32'(bus.REQ_OK[0]), 32'h0);
        tick();
        chk("midwr_refetch_addr", 32'(bus.ROM_ADDR), 32'h090777);
        tick_n(2);
        chk("midwr_req_ok", 32'(bus.REQ_OK[0]), 32'h1);
        chk("midwr_req_data", 32'(bus.REQ_DATA[7:0]), 32'(rom_byte(21'h090777)));
        tick_n(2);

        // Asynchronous reset during WAIT
        set_addr(0, 'h00778);
        tick();
        chk("rst_pre_cs", 32'(bus.ROM_CS), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_cs", 32'(bus.ROM_CS), 32'h0);
        chk("async_rst_ok", 32'(bus.REQ_OK), 32'h0);
        @(negedge clk);
        check_all();
        rst = 1'b0;
        tick();
        chk("post_rst_addr", 32'(bus.ROM_ADDR), 32'h000778);
        tick_n(8);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            bus.ROM_OK = ($urandom_range(0, 99) < 40);
            bus.WR     = ($urandom_range(0, 99) < 6);
            bus.WSEL   = 3'($urandom);
            bus.WDATA  = 8'($urandom);
            if ($urandom_range(0, 99) < 15)
                set_addr(int'($urandom_range(0, CHIPS - 1)), pool[$urandom_range(0, 7)]);
            tick();
        end
        bus.WR = 1'b0;
        bus.ROM_OK = 1'b1;
        tick_n(10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
